// File: rtl/timer_pkg.sv
// Shared types and helpers for the countdown timer: digit width, FSM states
// and the preset digit clamp.
package timer_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } timer_state_e;

    // Out-of-range preset digits become the largest legal digit.
    function automatic logic [DIGIT_W-1:0] clampDigit(
        input logic [DIGIT_W-1:0] digit,
        input int                 modValue
    );
        if (int'(digit) >= modValue) begin
            return DIGIT_W'(modValue - 1);
        end
        return digit;
    endfunction

endpackage

// File: rtl/digit_down_count.sv
// One radix-MOD_VALUE down-counting digit. A decrement at zero wraps to the
// top digit value and raises borrow for the next digit up.
module digit_down_count #(
    parameter int MOD_VALUE = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       decrement,
    output logic [3:0] count,
    output logic       borrow
);
    import timer_pkg::*;

    localparam logic [3:0] MaxDigit = 4'(MOD_VALUE - 1);

    logic [3:0] count_q;
    logic [3:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (decrement) begin
            count_d = (count_q == 4'd0) ? MaxDigit : count_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign borrow = decrement && (count_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// Multi-digit down-counting timer: loads a clamped preset, decrements once per
// tick while running and flags expiry when the count reaches zero.
module countdown_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int MOD_VALUE  = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [4*NUM_DIGITS-1:0] preset,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                  running,
    output logic                  paused,
    output logic                  expired,
    output logic                  done_pulse
);
    import timer_pkg::*;

    localparam int W = DIGIT_W * NUM_DIGITS;

    timer_state_e          state_q;
    logic                  donePulse_q;
    logic [W-1:0]          presetClamped;
    logic [W-1:0]          countAll;
    logic [NUM_DIGITS-1:0] decrement;
    logic [NUM_DIGITS-1:0] borrow;
    logic                  runTick;
    logic                  countIsZero;
    logic                  countIsOne;
    logic                  unusedTopBorrow;

    assign countIsZero = (countAll == '0);
    assign countIsOne  = (countAll == W'(1));

    // The zero guard keeps the chain from ever borrowing out of the top digit.
    assign runTick = (state_q == RUN) && tick && !pause && !load && !countIsZero;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign presetClamped[gi*DIGIT_W +: DIGIT_W] =
                clampDigit(preset[gi*DIGIT_W +: DIGIT_W], MOD_VALUE);

            if (gi == 0) begin : g_lsd
                assign decrement[gi] = runTick;
            end else begin : g_upper
                assign decrement[gi] = borrow[gi-1] & runTick;
            end

            digit_down_count #(
                .MOD_VALUE(MOD_VALUE)
            ) u_digit (
                .clk       (clk),
                .reset_n   (reset_n),
                .load      (load),
                .load_value(presetClamped[gi*DIGIT_W +: DIGIT_W]),
                .decrement (decrement[gi]),
                .count     (countAll[gi*DIGIT_W +: DIGIT_W]),
                .borrow    (borrow[gi])
            );
        end
    endgenerate

    assign unusedTopBorrow = borrow[NUM_DIGITS-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            donePulse_q <= 1'b0;
        end else begin
            donePulse_q <= 1'b0;
            if (load) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            if (countIsZero) begin
                                state_q     <= EXPIRED;
                                donePulse_q <= 1'b1;
                            end else begin
                                state_q <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (pause) begin
                            state_q <= PAUSED;
                        end else if (tick && countIsOne) begin
                            state_q     <= EXPIRED;
                            donePulse_q <= 1'b1;
                        end
                    end
                    PAUSED: begin
                        if (start) begin
                            state_q <= RUN;
                        end
                    end
                    EXPIRED: begin
                        state_q <= EXPIRED;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign count      = countAll;
    assign running    = (state_q == RUN);
    assign paused     = (state_q == PAUSED);
    assign expired    = (state_q == EXPIRED);
    assign done_pulse = donePulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by
// randomized traffic, all checked against an integer-valued reference model.
module tb_countdown_timer;

    localparam int ND  = 4;
    localparam int MOD = 10;

    localparam int S_IDLE    = 0;
    localparam int S_RUN     = 1;
    localparam int S_PAUSED  = 2;
    localparam int S_EXPIRED = 3;

    logic            clk;
    logic            reset_n;
    logic            load;
    logic [4*ND-1:0] preset;
    logic            start;
    logic            pause;
    logic            tick;
    logic [4*ND-1:0] count;
    logic            running;
    logic            paused;
    logic            expired;
    logic            done_pulse;

    int testCount;
    int failCount;

    int mVal;
    int mState;
    bit mDone;

    countdown_timer #(
        .NUM_DIGITS(ND),
        .MOD_VALUE (MOD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .preset    (preset),
        .start     (start),
        .pause     (pause),
        .tick      (tick),
        .count     (count),
        .running   (running),
        .paused    (paused),
        .expired   (expired),
        .done_pulse(done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int presetToValue(input logic [4*ND-1:0] p);
        int v;
        int d;
        v = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            d = int'(p[4*i +: 4]);
            if (d > MOD - 1) d = MOD - 1;
            v = v * MOD + d;
        end
        return v;
    endfunction

    function automatic logic [4*ND-1:0] valueToCount(input int v);
        logic [4*ND-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'(rem % MOD);
            rem = rem / MOD;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed,
                     expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".count"}, 32'(count), 32'(valueToCount(mVal)));
        checkOutput({tag, ".running"}, 32'(running), 32'(mState == S_RUN));
        checkOutput({tag, ".paused"}, 32'(paused), 32'(mState == S_PAUSED));
        checkOutput({tag, ".expired"}, 32'(expired), 32'(mState == S_EXPIRED));
        checkOutput({tag, ".done"}, 32'(done_pulse), 32'(mDone));
    endtask

    // Reference behaviour for one clock edge, from the timer's rules.
    task automatic modelStep(input bit ld, input logic [4*ND-1:0] pre, input bit st,
                             input bit pa, input bit tk);
        mDone = 1'b0;
        if (ld) begin
            mVal   = presetToValue(pre);
            mState = S_IDLE;
        end else begin
            case (mState)
                S_IDLE: if (st) begin
                    if (mVal == 0) begin
                        mState = S_EXPIRED;
                        mDone  = 1'b1;
                    end else begin
                        mState = S_RUN;
                    end
                end
                S_RUN: if (pa) begin
                    mState = S_PAUSED;
                end else if (tk) begin
                    mVal = mVal - 1;
                    if (mVal == 0) begin
                        mState = S_EXPIRED;
                        mDone  = 1'b1;
                    end
                end
                S_PAUSED: if (st) mState = S_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input string tag, input bit ld, input logic [4*ND-1:0] pre,
                                 input bit st, input bit pa, input bit tk);
        load   = ld;
        preset = pre;
        start  = st;
        pause  = pa;
        tick   = tk;
        @(posedge clk);
        modelStep(ld, pre, st, pa, tk);
        #1;
        checkAll(tag);
    endtask

    task automatic modelReset();
        mVal   = 0;
        mState = S_IDLE;
        mDone  = 1'b0;
    endtask

    initial begin
        logic [4*ND-1:0] rp;
        bit rl, rs, rpa, rt;

        testCount = 0;
        failCount = 0;
        modelReset();
        reset_n = 1'b0;
        load    = 1'b0;
        preset  = '0;
        start   = 1'b0;
        pause   = 1'b0;
        tick    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset");
        reset_n = 1'b1;

        // Asynchronous reset while running
        applyStimulus("s1.load", 1, 16'h0043, 0, 0, 0);
        applyStimulus("s1.start", 0, 16'h0, 1, 0, 0);
        applyStimulus("s1.tick", 0, 16'h0, 0, 0, 1);
        #1;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("s1.asyncReset");
        #2;
        reset_n = 1'b1;

        // Borrow rippling through two digits
        applyStimulus("s2.load", 1, 16'h0102, 0, 0, 0);
        applyStimulus("s2.start", 0, 16'h0, 1, 0, 0);
        applyStimulus("s2.t1", 0, 16'h0, 0, 0, 1);
        applyStimulus("s2.t2", 0, 16'h0, 0, 0, 1);
        applyStimulus("s2.t3", 0, 16'h0, 0, 0, 1);
        checkOutput("s2.count0099", 32'(count), 32'h0099);

        // Expiry from one, then stays expired
        applyStimulus("s3.load", 1, 16'h0001, 0, 0, 0);
        applyStimulus("s3.start", 0, 16'h0, 1, 0, 0);
        applyStimulus("s3.tick", 0, 16'h0, 0, 0, 1);
        checkOutput("s3.donePulse", 32'(done_pulse), 32'h1);
        for (int i = 0; i < 5; i++) applyStimulus("s3.extraTick", 0, 16'h0, 0, 0, 1);
        applyStimulus("s3.extraStart", 0, 16'h0, 1, 0, 0);

        // Pause wins over a same-cycle tick
        applyStimulus("s4.load", 1, 16'h0050, 0, 0, 0);
        applyStimulus("s4.start", 0, 16'h0, 1, 0, 0);
        applyStimulus("s4.pauseTick", 0, 16'h0, 0, 1, 1);
        applyStimulus("s4.pausedTick", 0, 16'h0, 0, 0, 1);
        applyStimulus("s4.resume", 0, 16'h0, 1, 0, 1);
        applyStimulus("s4.tick", 0, 16'h0, 0, 0, 1);
        checkOutput("s4.count0049", 32'(count), 32'h0049);

        // Digit clamp and load during RUN
        applyStimulus("s5.clamp", 1, 16'h00A5, 0, 0, 0);
        checkOutput("s5.count0095", 32'(count), 32'h0095);
        applyStimulus("s5.start", 0, 16'h0, 1, 0, 0);
        applyStimulus("s5.loadRun", 1, 16'h0300, 0, 0, 1);
        applyStimulus("s5.clampAll", 1, 16'hFFFF, 0, 0, 0);

        // Start at zero and load priority over start
        applyStimulus("s6.load0", 1, 16'h0000, 0, 0, 0);
        applyStimulus("s6.start0", 0, 16'h0, 1, 0, 0);
        applyStimulus("s6.after", 0, 16'h0, 1, 0, 1);
        applyStimulus("s6.loadStart", 1, 16'h0007, 1, 0, 1);
        checkOutput("s6.notRunning", 32'(running), 32'h0);

        // Randomized traffic, biased toward small presets so expiry occurs
        for (int n = 0; n < 3000; n++) begin
            rl = ($urandom_range(0, 39) == 0);
            rp = '0;
            for (int d = 0; d < ND; d++) begin
                if (d < 2 || $urandom_range(0, 3) == 0) rp[4*d +: 4] = 4'($urandom_range(0, 15));
            end
            rs  = ($urandom_range(0, 7) == 0);
            rpa = ($urandom_range(0, 11) == 0);
            rt  = ($urandom_range(0, 1) == 0);
            applyStimulus("rand", rl, rp, rs, rpa, rt);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
